// File: rtl/four_way_arb_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package four_way_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
        onehot4      = '0;
        onehot4[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/four_way_mux_arbiter_rr_pick.sv
// Combinational round-robin pick: first unmasked request after 'last', wrapping modulo 4.
module rr_priority_pick
    import four_way_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    input  logic [NUM_REQ-1:0] mask,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    logic [NUM_REQ-1:0] masked;
    logic [SEL_W-1:0]   idx;

    assign masked = req & ~mask;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = SEL_W'(32'(last) + k);
            if (!any && masked[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/four_way_mux_arbiter.sv
// Round-robin arbiter sharing one registered 16-bit four-way select path.
// Optional hold limit enabled by defining FOUR_WAY_ARB_HOLD_LIMIT_EN.
module four_way_mux_arbiter
    import four_way_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned HOLD_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [DATA_W-1:0]   in1,
    input  logic [DATA_W-1:0]   in2,
    input  logic [DATA_W-1:0]   in3,
    input  logic [DATA_W-1:0]   in4,
    output logic [NUM_REQ-1:0]  grant,
    output logic [SEL_W-1:0]    sel,
    output logic [DATA_W-1:0]   out,
    output logic                valid_out,
    output logic                busy
);

    if (HOLD_LIMIT < 2) begin : g_bad_hold_limit
        $error("HOLD_LIMIT must be at least 2");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]  out_q;
    logic               valid_q;

    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_winner;
    logic               take;
    logic               hold_expired;
    logic [DATA_W-1:0]  in_sel;

`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
    localparam int unsigned   CNT_W   = $clog2(HOLD_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hold_expired = (cnt_q == CNT_MAX);
`else
    assign hold_expired = 1'b0;
`endif

    // Masking the holder only matters for a forced switch; on release its req is already 0.
    assign pick_mask = (state_q == ARB_GRANT) ? onehot4(sel_q) : '0;

    rr_priority_pick u_pick (
        .req    (req),
        .last   (last_q),
        .mask   (pick_mask),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        take    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                take = pick_any;
            end
            ARB_GRANT: begin
                if (!req[sel_q]) begin
                    if (pick_any) begin
                        take = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end else if (hold_expired && pick_any) begin
                    take = 1'b1;
                end
`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
                else if (!hold_expired) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: ;
        endcase

        if (take) begin
            state_d = ARB_GRANT;
            grant_d = onehot4(pick_winner);
            sel_d   = pick_winner;
            last_d  = pick_winner;
`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
            cnt_d   = '0;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        in_sel = in1;
        case (sel_q)
            2'd0: in_sel = in1;
            2'd1: in_sel = in2;
            2'd2: in_sel = in3;
            2'd3: in_sel = in4;
            default: in_sel = in1;
        endcase
    end

    // Data follows the grant already registered, giving one cycle of latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else if (grant_q != '0) begin
            out_q   <= in_sel;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out       = out_q;
    assign valid_out = valid_q;
    assign busy      = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_four_way_mux_arbiter.sv
// Self-checking bench for four_way_mux_arbiter; honours FOUR_WAY_ARB_HOLD_LIMIT_EN.
module tb_four_way_mux_arbiter;

    localparam int DW = 16;
    localparam int HL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = '0;
    logic [DW-1:0] d_in [4];
    logic [3:0]    grant;
    logic [1:0]    sel;
    logic [DW-1:0] out;
    logic          valid_out;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: holder index (-1 when idle), round-robin pointer, hold count.
    int            m_holder;
    int            m_last;
    int            m_cnt;
    int            m_sel;
    logic [DW-1:0] m_out;
    bit            m_valid;

    always #5 clk = ~clk;

    four_way_mux_arbiter #(.DATA_W(DW), .HOLD_LIMIT(HL)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .req       (req),
        .in1       (d_in[0]),
        .in2       (d_in[1]),
        .in3       (d_in[2]),
        .in4       (d_in[3]),
        .grant     (grant),
        .sel       (sel),
        .out       (out),
        .valid_out (valid_out),
        .busy      (busy)
    );

    function automatic int pick(input logic [3:0] r, input int last, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_grant();
        return (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_last   = 3;
        m_cnt    = 0;
        m_sel    = 0;
        m_out    = '0;
        m_valid  = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [DW-1:0] d [4]);
        int  w;
        bit  hold_en;
`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
        hold_en = 1'b1;
`else
        hold_en = 1'b0;
`endif
        if (m_holder >= 0) begin
            m_out   = d[m_holder];
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        w = -1;
        if (m_holder < 0) begin
            w = pick(r, m_last, -1);
        end else if (!r[m_holder]) begin
            w = pick(r, m_last, m_holder);
            if (w < 0) m_holder = -1;
        end else if (hold_en && m_cnt == HL - 1 && pick(r, m_last, m_holder) >= 0) begin
            w = pick(r, m_last, m_holder);
        end else begin
            m_cnt = (m_cnt + 1 > HL - 1) ? HL - 1 : m_cnt + 1;
        end
        if (w >= 0) begin
            m_holder = w;
            m_sel    = w;
            m_last   = w;
            m_cnt    = 0;
        end
    endtask

    task automatic tick();
        logic [3:0]    r;
        logic [DW-1:0] d [4];
        r = req;
        d = d_in;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, sel, out, valid_out, busy} !== {4'b0000, 2'd0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b sel=%0d out=%h valid=%b busy=%b, expected all zero",
                     grant, sel, out, valid_out, busy);
        end
        apply_reset();
        tick();
        n_checks++;
        if ({grant, valid_out, busy} !== {4'b0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_no_req: grant=%b valid=%b busy=%b, expected 0000/0/0", grant, valid_out, busy);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        d_in[0] = 16'h1111; d_in[1] = 16'h2222; d_in[2] = 16'h3333; d_in[3] = 16'h4444;
        req = 4'b1111;
        tick();
        n_checks++;
        if ({grant, sel, busy} !== {4'b0001, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL first_grant: grant=%b sel=%0d busy=%b, expected 0001/0/1", grant, sel, busy);
        end
        tick();
        n_checks++;
        if ({out, valid_out} !== {16'h1111, 1'b1}) begin
            n_fail++;
            $display("FAIL first_data: out=%h valid=%b, expected 1111/1", out, valid_out);
        end
        req = 4'b1010;
        tick();
        n_checks++;
        if ({grant, sel, busy} !== {4'b0010, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL rr_to_1: grant=%b sel=%0d busy=%b, expected 0010/1/1", grant, sel, busy);
        end
        req = 4'b1000;
        tick();
        n_checks++;
        if ({grant, sel, busy, valid_out} !== {4'b1000, 2'd3, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL rr_to_3: grant=%b sel=%0d busy=%b valid=%b, expected 1000/3/1/1",
                     grant, sel, busy, valid_out);
        end
        req = 4'b0010;
        tick();
        n_checks++;
        if ({grant, sel, busy, valid_out, out} !== {4'b0010, 2'd1, 1'b1, 1'b1, 16'h4444}) begin
            n_fail++;
            $display("FAIL rr_wrap_to_1: grant=%b sel=%0d busy=%b valid=%b out=%h, expected 0010/1/1/1/4444",
                     grant, sel, busy, valid_out, out);
        end
    endtask

    task automatic test_hold_limit();
        logic [3:0] exp_g;
        int         ncyc;
        apply_reset();
        req = 4'b0011;
`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
        ncyc = 4 * HL;
`else
        ncyc = 100;
`endif
        for (int c = 0; c < ncyc; c++) begin
            tick();
`ifdef FOUR_WAY_ARB_HOLD_LIMIT_EN
            exp_g = (((c / HL) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
            exp_g = 4'b0001;
`endif
            n_checks++;
            if (grant !== exp_g) begin
                n_fail++;
                $display("FAIL hold_limit cycle %0d: grant=%b, expected %b", c, grant, exp_g);
            end
        end
    endtask

    task automatic test_sole_requester();
        apply_reset();
        d_in[2] = 16'hC3C3;
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if ({grant, sel, busy} !== {4'b0100, 2'd2, 1'b1}) begin
                n_fail++;
                $display("FAIL sole_hold cycle %0d: grant=%b sel=%0d busy=%b, expected 0100/2/1",
                         c, grant, sel, busy);
            end
        end
        req = 4'b0000;
        tick();
        d_in[2] = 16'h5A5A;
        n_checks++;
        if ({grant, sel, busy, valid_out, out} !== {4'b0000, 2'd2, 1'b0, 1'b1, 16'hC3C3}) begin
            n_fail++;
            $display("FAIL sole_release: grant=%b sel=%0d busy=%b valid=%b out=%h, expected 0000/2/0/1/c3c3",
                     grant, sel, busy, valid_out, out);
        end
        tick();
        n_checks++;
        if ({valid_out, out} !== {1'b0, 16'hC3C3}) begin
            n_fail++;
            $display("FAIL sole_out_hold: valid=%b out=%h, expected 0/c3c3", valid_out, out);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        d_in[1] = 16'hBEEF;
        req = 4'b0010;
        tick();
        tick();
        n_checks++;
        if ({grant, out, valid_out} !== {4'b0010, 16'hBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL async_pre: grant=%b out=%h valid=%b, expected 0010/beef/1", grant, out, valid_out);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({grant, sel, out, valid_out, busy} !== {4'b0000, 2'd0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_clear: grant=%b sel=%0d out=%h valid=%b busy=%b, expected all zero",
                     grant, sel, out, valid_out, busy);
        end
        #1;
        rst_n = 1'b1;
        req = 4'b0110;
        tick();
        n_checks++;
        if ({grant, sel} !== {4'b0010, 2'd1}) begin
            n_fail++;
            $display("FAIL async_ptr_reset: grant=%b sel=%0d, expected 0010/1", grant, sel);
        end
    endtask

    task automatic test_simultaneous_release();
        apply_reset();
        d_in[0] = 16'hA0A0; d_in[2] = 16'hC2C2;
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0001;
        tick();
        n_checks++;
        if ({grant, sel, valid_out, out} !== {4'b0001, 2'd0, 1'b1, 16'hC2C2}) begin
            n_fail++;
            $display("FAIL simul_switch: grant=%b sel=%0d valid=%b out=%h, expected 0001/0/1/c2c2",
                     grant, sel, valid_out, out);
        end
        tick();
        n_checks++;
        if ({valid_out, out} !== {1'b1, 16'hA0A0}) begin
            n_fail++;
            $display("FAIL simul_data: valid=%b out=%h, expected 1/a0a0", valid_out, out);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) d_in[i] = 16'($urandom);
            tick();
            n_checks++;
            if ({grant, sel, valid_out, busy} !== {m_grant(), 2'(m_sel), m_valid, (m_holder >= 0)}) begin
                n_fail++;
                $display("FAIL random_ctrl cycle %0d: grant=%b sel=%0d valid=%b busy=%b, expected %b/%0d/%b/%b",
                         c, grant, sel, valid_out, busy, m_grant(), m_sel, m_valid, (m_holder >= 0));
            end
            n_checks++;
            if (out !== m_out) begin
                n_fail++;
                $display("FAIL random_out cycle %0d: out=%h, expected %h", c, out, m_out);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) d_in[i] = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_hold_limit();
        test_sole_requester();
        test_async_reset();
        test_simultaneous_release();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
